// File: rtl/lsh_seq_ctrl.sv
// Multi-cycle left-shift sequencer that drives an external even-step shifter.
// The shift amount is split into an optional internal 1-bit step and a run of even steps of at most MAXF codes each.
module lsh_seq_ctrl #(
  parameter int W    = 14,
  parameter int AW   = 4,
  parameter int MAXF = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic [W-1:0]  lsh_a,
  output logic [2:0]    lsh_f,
  input  logic [W-1:0]  lsh_y
);

  typedef enum logic [1:0] {IDLE, ODD, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] rem_q, rem_d;

  logic [AW-1:0] half_rem;
  logic [2:0]    step_code;
  logic [AW-1:0] rem_after_step;

  // Largest even step still owed, capped at what the shifter may do in one cycle.
  assign half_rem       = rem_q >> 1;
  assign step_code      = (half_rem > AW'(MAXF)) ? 3'(MAXF) : half_rem[2:0];
  assign rem_after_step = rem_q - (AW'(step_code) << 1);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign lsh_a     = acc_q;
  assign lsh_f     = (state_q == SHIFT) ? step_code : 3'd0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d = in_data;
          rem_d = in_amt;
          if (32'(in_amt) >= W) begin
            acc_d   = '0;
            state_d = DONE;
          end else if (in_amt == '0) begin
            state_d = DONE;
          end else if (in_amt[0]) begin
            state_d = ODD;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      ODD: begin
        acc_d   = {acc_q[W-2:0], 1'b0};
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == AW'(1)) ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_d   = lsh_y;
        rem_d   = rem_after_step;
        state_d = (rem_after_step == '0) ? DONE : SHIFT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_lsh_seq_ctrl.sv
// Directed and randomised bench for lsh_seq_ctrl; one instance per MAXF value 1..6,
// each wired to a behavioural even-step shifter.
module tb_lsh_seq_ctrl;

  localparam int W  = 14;
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          in_valid  [1:6];
  logic          in_ready  [1:6];
  logic [W-1:0]  in_data   [1:6];
  logic [AW-1:0] in_amt    [1:6];
  logic          out_valid [1:6];
  logic          out_ready [1:6];
  logic [W-1:0]  out_data  [1:6];
  logic          busy      [1:6];
  logic [W-1:0]  lsh_a     [1:6];
  logic [2:0]    lsh_f     [1:6];
  logic [W-1:0]  lsh_y     [1:6];

  int n_vec;
  int n_err;

  for (genvar g = 1; g <= 6; g++) begin : g_dut
    lsh_seq_ctrl #(.W(W), .AW(AW), .MAXF(g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_amt    (in_amt[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g]),
      .lsh_a     (lsh_a[g]),
      .lsh_f     (lsh_f[g]),
      .lsh_y     (lsh_y[g])
    );
    // External shifter: code f shifts left by 2*f, code 7 yields zero.
    assign lsh_y[g] = (lsh_f[g] == 3'd7) ? '0 : W'(lsh_a[g] << (2 * lsh_f[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on instance k, holds out_ready low for `hold` cycles once DONE is reached.
  task automatic run_op(input int k, input logic [W-1:0] data, input logic [AW-1:0] amt,
                        input int hold, output int lat, output logic [W-1:0] res,
                        output int nshift, output int maxc);
    lat = 0; nshift = 0; maxc = 0; res = '0;
    check_eq("ready_before_op", 32'(in_ready[k]), 32'd1);
    in_valid[k]  = 1'b1;
    in_data[k]   = data;
    in_amt[k]    = amt;
    out_ready[k] = (hold == 0);
    tick();
    lat = 1;
    in_valid[k] = 1'b0;
    in_data[k]  = W'($urandom);
    in_amt[k]   = AW'($urandom);
    while (!out_valid[k] && lat < 40) begin
      if (lsh_f[k] != 3'd0) nshift++;
      if (int'(lsh_f[k]) > maxc) maxc = int'(lsh_f[k]);
      tick();
      lat++;
    end
    check_eq("out_valid_reached", 32'(out_valid[k]), 32'd1);
    res = out_data[k];
    for (int i = 0; i < hold; i++) begin
      check_eq("bp_in_ready", 32'(in_ready[k]), 32'd0);
      check_eq("bp_out_valid", 32'(out_valid[k]), 32'd1);
      check_eq("bp_out_data", 32'(out_data[k]), 32'(res));
      tick();
    end
    out_ready[k] = 1'b1;
    tick();
    check_eq("idle_after_done", 32'(in_ready[k]), 32'd1);
    check_eq("valid_drop_after_done", 32'(out_valid[k]), 32'd0);
    out_ready[k] = 1'b0;
  endtask

  int             lat, nshift, maxc;
  logic [W-1:0]   res;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_amt[i]    = '0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 1; i <= 6; i++) begin
      check_eq("rst_in_ready", 32'(in_ready[i]), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check_eq("rst_busy", 32'(busy[i]), 32'd0);
      check_eq("rst_lsh_f", 32'(lsh_f[i]), 32'd0);
      check_eq("rst_lsh_a", 32'(lsh_a[i]), 32'd0);
    end
    tick();

    // Reset mid-op: 1 << 8 on MAXF=1, interrupted while in SHIFT.
    in_valid[1] = 1'b1; in_data[1] = 14'h0001; in_amt[1] = 4'd8;
    tick();
    in_valid[1] = 1'b0;
    check_eq("mid_shift_f", 32'(lsh_f[1]), 32'd1);
    check_eq("mid_busy", 32'(busy[1]), 32'd1);
    tick();
    check_eq("mid_acc", 32'(lsh_a[1]), 32'h0004);
    reset = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid[1]), 32'd0);
    check_eq("arst_busy", 32'(busy[1]), 32'd0);
    check_eq("arst_lsh_f", 32'(lsh_f[1]), 32'd0);
    check_eq("arst_lsh_a", 32'(lsh_a[1]), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready[1]), 32'd1);
    check_eq("post_rst_acc", 32'(lsh_a[1]), 32'd0);
    check_eq("post_rst_valid", 32'(out_valid[1]), 32'd0);

    // MAXF=1, 1 << 5: ODD then two SHIFT steps of code 1.
    run_op(1, 14'h0001, 4'd5, 0, lat, res, nshift, maxc);
    check_eq("t2_lat", 32'(lat), 32'd4);
    check_eq("t2_data", 32'(res), 32'h0020);
    check_eq("t2_nshift", 32'(nshift), 32'd2);
    check_eq("t2_maxc", 32'(maxc), 32'd1);

    // MAXF=6, 1FFF << 13: ODD then one SHIFT of code 6.
    run_op(6, 14'h1FFF, 4'd13, 0, lat, res, nshift, maxc);
    check_eq("t3_lat", 32'(lat), 32'd3);
    check_eq("t3_data", 32'(res), 32'h2000);
    check_eq("t3_nshift", 32'(nshift), 32'd1);
    check_eq("t3_maxc", 32'(maxc), 32'd6);

    // Zero amount and amounts at/above the width.
    run_op(3, 14'h1234, 4'd0, 0, lat, res, nshift, maxc);
    check_eq("t4_amt0_lat", 32'(lat), 32'd1);
    check_eq("t4_amt0_data", 32'(res), 32'h1234);
    run_op(3, 14'h3FFF, 4'd14, 0, lat, res, nshift, maxc);
    check_eq("t4_amt14_lat", 32'(lat), 32'd1);
    check_eq("t4_amt14_data", 32'(res), 32'h0000);
    check_eq("t4_amt14_nshift", 32'(nshift), 32'd0);
    run_op(2, 14'h2AAA, 4'd15, 0, lat, res, nshift, maxc);
    check_eq("t4_amt15_lat", 32'(lat), 32'd1);
    check_eq("t4_amt15_data", 32'(res), 32'h0000);

    // Back-pressure: MAXF=2, 0x0155 << 6 -> SHIFT codes 2,1, held 10 cycles in DONE.
    run_op(2, 14'h0155, 4'd6, 10, lat, res, nshift, maxc);
    check_eq("t5_lat", 32'(lat), 32'd3);
    check_eq("t5_data", 32'(res), 32'h1540);
    check_eq("t5_nshift", 32'(nshift), 32'd2);

    // Random ops across all MAXF instances.
    for (int n = 0; n < 1000; n++) begin
      int            k;
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      int            exp_lat;
      logic [31:0]   exp_data;
      k = int'($urandom_range(1, 6));
      d = W'($urandom);
      a = AW'($urandom);
      exp_data = (32'(d) << a) & 32'h3FFF;
      if (a == 0 || int'(a) >= W) exp_lat = 1;
      else exp_lat = 1 + int'(a[0]) + (int'(a >> 1) + k - 1) / k;
      run_op(k, d, a, int'($urandom_range(0, 3)), lat, res, nshift, maxc);
      check_eq("rnd_lat", 32'(lat), 32'(exp_lat));
      check_eq("rnd_data", 32'(res), exp_data);
      check_eq("rnd_code_limit", 32'(maxc <= k), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
